froc_sink_checker: RTL and testbench

//  Consumer of the signal bus: watches FRoC's state and sink outputs, waits a settle window after each

---
 rtl/froc_pkg.sv | 28 ++
 rtl/froc_popcount.sv | 25 ++
 rtl/froc_sink_checker.sv | 200 ++++++++++++++++++++
 tb/tb_froc_sink_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/froc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : froc_pkg                                                    |
// | Description : Shared types for the FRoC sink checker: checker FSM states, |
// |               the result record layout and the record field widths.      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package froc_pkg;

    localparam int c_state_length = 8;
    localparam int c_num_sinks    = 16;
    localparam int c_nfail_w      = $clog2(c_num_sinks + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REPORT = 2'd2
    } chk_state_e;

    // Record layout matches the default STATE_LENGTH / NUM_SINKS of the checker
    typedef struct packed {
        logic [c_state_length-1:0] state;
        logic [c_num_sinks-1:0]    diff;
        logic [c_nfail_w-1:0]      nfail;
    } result_t;

endpackage
`default_nettype wire

// File: rtl/froc_popcount.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : froc_popcount                                               |
// | Description : Combinational count of set bits in a W-bit vector.          |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module froc_popcount #(
    parameter int W = 16
) (
    input  logic [W-1:0]             din,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int c_cw = $clog2(W + 1);

    // Sum every input bit into the count
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + c_cw'(din[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/froc_sink_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : froc_sink_checker                                           |
// | Description : Watches the FRoC state/sink bus, waits a settle window after|
// |               each state change, compares sinks against the golden       |
// |               vector and emits one result record per tested state over a  |
// |               valid/ready handshake. Keeps saturating run-wide totals.   |
// |               Optional macro FROC_STICKY_MASK_EN adds clear_mask /        |
// |               sticky_mask (accumulated OR of reported diffs).             |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module froc_sink_checker
    import froc_pkg::*;
#(
    parameter int STATE_LENGTH  = c_state_length,
    parameter int NUM_SINKS     = c_num_sinks,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [STATE_LENGTH-1:0]          state,
    input  logic [NUM_SINKS-1:0]             sinks,
    input  logic [NUM_SINKS-1:0]             expected,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [STATE_LENGTH-1:0]          res_state,
    output logic [NUM_SINKS-1:0]             res_diff,
    output logic [$clog2(NUM_SINKS+1)-1:0]   res_nfail,
    output logic [CNT_W-1:0]                 total_fail,
    output logic [CNT_W-1:0]                 abort_cnt,
    output logic [CNT_W-1:0]                 overrun_cnt
`ifdef FROC_STICKY_MASK_EN
    ,
    input  logic                             clear_mask,
    output logic [NUM_SINKS-1:0]             sticky_mask
`endif
);

    localparam logic [7:0] c_settle_reload = 8'(SETTLE_CYCLES - 1);

    logic                            r_primed;
    logic [STATE_LENGTH-1:0]         r_state_q;
    chk_state_e                      r_fsm, w_fsm_nxt;
    logic [7:0]                      r_cnt, w_cnt_nxt;
    logic [STATE_LENGTH-1:0]         r_tstate, w_tstate_nxt;
    result_t                         r_rec, w_rec_nxt;
    logic                            r_pend, w_pend_nxt;
    logic [STATE_LENGTH-1:0]         r_pend_state, w_pend_state_nxt;
    logic [CNT_W-1:0]                r_total_fail, r_abort_cnt, r_overrun_cnt;
    logic                            w_chg, w_hs, w_abort, w_overrun, w_fail_hs;
    logic [NUM_SINKS-1:0]            w_diff;
    logic [$clog2(NUM_SINKS+1)-1:0]  w_nfail;

    // The first edge after reset only primes the state history, so an
    // arbitrary bus state at reset release never produces a record.
    assign w_chg  = enable && r_primed && (state != r_state_q);
    assign w_diff = sinks ^ expected;
    assign w_hs   = res_valid && res_ready;

    froc_popcount #(.W(NUM_SINKS)) u_popcount (
        .din   (w_diff),
        .count (w_nfail)
    );

    // State history tracks the bus every cycle, even while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_primed  <= 1'b0;
            r_state_q <= '0;
        end else begin
            r_primed  <= 1'b1;
            r_state_q <= state;
        end
    end

    // FSM and record registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm        <= IDLE;
            r_cnt        <= '0;
            r_tstate     <= '0;
            r_rec        <= '0;
            r_pend       <= 1'b0;
            r_pend_state <= '0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tstate     <= w_tstate_nxt;
            r_rec        <= w_rec_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_state <= w_pend_state_nxt;
        end
    end

    // Next-state logic: settle countdown, capture, report with one-deep pending slot
    always_comb begin
        w_fsm_nxt        = r_fsm;
        w_cnt_nxt        = r_cnt;
        w_tstate_nxt     = r_tstate;
        w_rec_nxt        = r_rec;
        w_pend_nxt       = r_pend;
        w_pend_state_nxt = r_pend_state;
        w_abort          = 1'b0;
        w_overrun        = 1'b0;
        w_fail_hs        = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (w_chg) begin
                    w_fsm_nxt    = SETTLE;
                    w_tstate_nxt = state;
                    w_cnt_nxt    = c_settle_reload;
                end
            end
            SETTLE: begin
                if (w_chg) begin
                    w_tstate_nxt = state;
                    w_cnt_nxt    = c_settle_reload;
                    w_abort      = 1'b1;
                end else if (r_cnt == 8'd0) begin
                    w_rec_nxt.state = r_tstate;
                    w_rec_nxt.diff  = w_diff;
                    w_rec_nxt.nfail = w_nfail;
                    w_fsm_nxt       = REPORT;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            REPORT: begin
                if (w_hs) begin
                    w_fail_hs = (r_rec.nfail != '0);
                    if (w_chg) begin
                        // A fresh change supersedes anything pending
                        w_fsm_nxt    = SETTLE;
                        w_tstate_nxt = state;
                        w_cnt_nxt    = c_settle_reload;
                        w_pend_nxt   = 1'b0;
                    end else if (r_pend) begin
                        w_fsm_nxt    = SETTLE;
                        w_tstate_nxt = r_pend_state;
                        w_cnt_nxt    = c_settle_reload;
                        w_pend_nxt   = 1'b0;
                    end else begin
                        w_fsm_nxt = IDLE;
                    end
                end else if (w_chg) begin
                    w_overrun        = r_pend;
                    w_pend_nxt       = 1'b1;
                    w_pend_state_nxt = state;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // Saturating run-wide counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total_fail  <= '0;
            r_abort_cnt   <= '0;
            r_overrun_cnt <= '0;
        end else begin
            if (w_fail_hs && (r_total_fail != {CNT_W{1'b1}}))
                r_total_fail <= r_total_fail + 1'b1;
            if (w_abort && (r_abort_cnt != {CNT_W{1'b1}}))
                r_abort_cnt <= r_abort_cnt + 1'b1;
            if (w_overrun && (r_overrun_cnt != {CNT_W{1'b1}}))
                r_overrun_cnt <= r_overrun_cnt + 1'b1;
        end
    end

    assign res_valid   = (r_fsm == REPORT);
    assign res_state   = r_rec.state;
    assign res_diff    = r_rec.diff;
    assign res_nfail   = r_rec.nfail;
    assign total_fail  = r_total_fail;
    assign abort_cnt   = r_abort_cnt;
    assign overrun_cnt = r_overrun_cnt;

`ifdef FROC_STICKY_MASK_EN
    logic [NUM_SINKS-1:0] r_sticky;

    // Accumulate reported diffs; clear takes priority over a same-cycle OR
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sticky <= '0;
        else if (clear_mask)
            r_sticky <= '0;
        else if (w_hs)
            r_sticky <= r_sticky | r_rec.diff;
    end

    assign sticky_mask = r_sticky;
`else
    // Sticky mask feature not built: no mask storage
`endif

endmodule
`default_nettype wire

// File: tb/tb_froc_sink_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_froc_sink_checker                                        |
// | Description : Scoreboard bench for froc_sink_checker. Stimulus pushes the |
// |               expected record; a negedge monitor compares presented      |
// |               records. Define FROC_STICKY_MASK_EN to cover the mask.     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_froc_sink_checker;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b1;
    logic [7:0]  state     = 8'h00;
    logic [15:0] sinks     = 16'h0000;
    logic [15:0] expected  = 16'h0000;
    logic        res_ready = 1'b1;
    logic        res_valid;
    logic [7:0]  res_state;
    logic [15:0] res_diff;
    logic [4:0]  res_nfail;
    logic [15:0] total_fail, abort_cnt, overrun_cnt;
`ifdef FROC_STICKY_MASK_EN
    logic        clear_mask = 1'b0;
    logic [15:0] sticky_mask;
`endif

    froc_sink_checker #(
        .STATE_LENGTH  (8),
        .NUM_SINKS     (16),
        .SETTLE_CYCLES (4),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .state       (state),
        .sinks       (sinks),
        .expected    (expected),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_state   (res_state),
        .res_diff    (res_diff),
        .res_nfail   (res_nfail),
        .total_fail  (total_fail),
        .abort_cnt   (abort_cnt),
        .overrun_cnt (overrun_cnt)
`ifdef FROC_STICKY_MASK_EN
        ,
        .clear_mask  (clear_mask),
        .sticky_mask (sticky_mask)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  st;
        logic [15:0] diff;
        logic [4:0]  nfail;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    bit   in_rec = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] st, input logic [15:0] d, input logic [4:0] nf, input int c);
        exp_t e;
        e.st = st; e.diff = d; e.nfail = nf; e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: compare every presented record against the scoreboard head
    always @(negedge clk) begin
        if (!reset && res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got state %0h, expected no record", res_state);
            end else begin
                if (!in_rec) begin
                    in_rec = 1'b1;
                    chk("latency", cyc, sb[0].cyc);
                end
                chk("rec_state", res_state, sb[0].st);
                chk("rec_diff", res_diff, sb[0].diff);
                chk("rec_nfail", res_nfail, sb[0].nfail);
                if (res_ready) begin
                    void'(sb.pop_front());
                    in_rec = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(3);
        reset = 1'b0;

        // Constant state after reset: no record, counters zero
        step(20);
        chk("idle_valid", res_valid, 0);
        chk("idle_total", total_fail, 0);
        chk("idle_abort", abort_cnt, 0);
        chk("idle_overrun", overrun_cnt, 0);

        // Clean compare
        expected = 16'h1234; sinks = 16'h1234; state = 8'h05;
        push(8'h05, 16'h0000, 5'd0, cyc + 5);
        step(8);
        chk("clean_total", total_fail, 0);

        // Two mismatching bits
        sinks = 16'h1335; state = 8'h07;
        push(8'h07, 16'h0101, 5'd2, cyc + 5);
        step(8);
        chk("two_bit_total", total_fail, 1);

        // Every bit wrong: full-width popcount
        sinks = 16'hEDCB; state = 8'h0A;
        push(8'h0A, 16'hFFFF, 5'd16, cyc + 5);
        step(8);
        chk("all_bit_total", total_fail, 2);

        // Change inside settle window restarts the test
        sinks = 16'h1234; state = 8'h01;
        step(2);
        state = 8'h02;
        push(8'h02, 16'h0000, 5'd0, cyc + 5);
        step(8);
        chk("abort_cnt", abort_cnt, 1);

        // Stalled consumer: pending slot overwritten twice
        res_ready = 1'b0; state = 8'h08;
        push(8'h08, 16'h0000, 5'd0, cyc + 5);
        step(6);
        state = 8'h03; step(1);
        state = 8'h04; step(1);
        state = 8'h05; step(2);
        chk("overrun_cnt", overrun_cnt, 2);
        chk("stall_valid", res_valid, 1);
        res_ready = 1'b1;
        push(8'h05, 16'h0000, 5'd0, cyc + 5);
        step(10);
        chk("overrun_hold", overrun_cnt, 2);

        // Disabled: change ignored, and re-enable does not fire on it
        enable = 1'b0; state = 8'h33;
        step(8);
        enable = 1'b1;
        step(8);
        chk("enable_abort", abort_cnt, 1);
        chk("enable_total", total_fail, 2);

`ifdef FROC_STICKY_MASK_EN
        clear_mask = 1'b1; step(1); clear_mask = 1'b0;
        chk("sticky_clear0", sticky_mask, 16'h0000);
        sinks = 16'h1235; state = 8'h40;
        push(8'h40, 16'h0001, 5'd1, cyc + 5);
        step(8);
        sinks = 16'h9234; state = 8'h41;
        push(8'h41, 16'h8000, 5'd1, cyc + 5);
        step(8);
        chk("sticky_or", sticky_mask, 16'h8001);
        clear_mask = 1'b1; step(1); clear_mask = 1'b0;
        chk("sticky_clear", sticky_mask, 16'h0000);
        sinks = 16'h1234;
`endif

        // Reset while a record is presented drops it immediately
        res_ready = 1'b0; state = 8'h50;
        push(8'h50, 16'h0000, 5'd0, cyc + 5);
        step(6);
        chk("pre_reset_valid", res_valid, 1);
        reset = 1'b1;
        #1;
        chk("reset_valid", res_valid, 0);
        chk("reset_total", total_fail, 0);
        chk("reset_abort", abort_cnt, 0);
        chk("reset_overrun", overrun_cnt, 0);
`ifdef FROC_STICKY_MASK_EN
        chk("reset_sticky", sticky_mask, 16'h0000);
`endif
        sb.delete();
        in_rec = 1'b0;
        res_ready = 1'b1;
        step(2);
        reset = 1'b0;
        step(10);
        chk("post_reset_valid", res_valid, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
